// File: rtl/dense_layer_pkg.sv
// Shared types and helpers for the sequential dense layer.
package dense_layer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH,
        OUTPUT
    } state_t;

    // Arithmetic shift (floor) followed by a clamp to a signed out_bits range.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] v,
        input int unsigned        shift,
        input int unsigned        out_bits
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = v >>> shift;
        hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_bits - 1));
        if (r > hi)
            return hi;
        else if (r < lo)
            return lo;
        else
            return r;
    endfunction

endpackage

// File: rtl/dense_layer_seq_mac.sv
// One neuron lane: full-precision signed product accumulated into a wide register.
module dense_mac_lane
    import dense_layer_pkg::*;
#(
    parameter int unsigned IN_BITS  = 16,
    parameter int unsigned W_BITS   = 16,
    parameter int unsigned ACC_BITS = 43
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       enable,
    input  logic signed [IN_BITS-1:0]  x,
    input  logic signed [W_BITS-1:0]   w,
    output logic signed [ACC_BITS-1:0] acc
);

    logic signed [IN_BITS+W_BITS-1:0] prod;

    assign prod = x * w;

    always_ff @(posedge clk) begin
        if (rst || clear)
            acc <= '0;
        else if (enable)
            acc <= acc + ACC_BITS'(prod);
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Fully-connected layer: streamed beats MAC into parallel lanes, then bias, ReLU,
// rescale and saturate, presented on a valid/ready output.
module dense_layer_seq
    import dense_layer_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 784,
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned IN_BITS     = 16,
    parameter int unsigned W_BITS      = 16,
    parameter int unsigned B_BITS      = 24,
    parameter int unsigned OUT_BITS    = 16,
    parameter int unsigned FRAC_SHIFT  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              relu_en,
    input  logic [NUM_NEURONS*B_BITS-1:0]     bias,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [IN_BITS-1:0]         in_x,
    input  logic [NUM_NEURONS*W_BITS-1:0]     in_w,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0]   out_data,
    output logic [$clog2(NUM_INPUTS)-1:0]     beat_idx
);

    localparam int unsigned IDX_BITS = $clog2(NUM_INPUTS);
    localparam int unsigned ACC_BITS = IN_BITS + W_BITS + $clog2(NUM_INPUTS) + 1;

    state_t state;
    logic   relu_q;
    logic   fin_q;
    logic   clear;
    logic   beat;

    logic signed [ACC_BITS-1:0] acc    [NUM_NEURONS];
    logic signed [ACC_BITS-1:0] biased [NUM_NEURONS];
    logic signed [ACC_BITS-1:0] sum_r  [NUM_NEURONS];

    assign clear = (state == IDLE) && start;
    assign beat  = in_ready && in_valid;

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
        dense_mac_lane #(
            .IN_BITS (IN_BITS),
            .W_BITS  (W_BITS),
            .ACC_BITS(ACC_BITS)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .enable(beat),
            .x     (in_x),
            .w     (in_w[g*W_BITS +: W_BITS]),
            .acc   (acc[g])
        );
    end

    always_comb begin
        for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
            biased[n] = acc[n] + ACC_BITS'(signed'(bias[n*B_BITS +: B_BITS]));
            if (relu_q && biased[n][ACC_BITS-1])
                biased[n] = '0;
        end
    end

    // FINISH registers bias+ReLU sums; the shift/clamp stage lands one cycle later
    // in OUTPUT (fin_q), so out_valid rises two cycles after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            beat_idx  <= '0;
            out_data  <= '0;
            relu_q    <= 1'b0;
            fin_q     <= 1'b0;
            for (int unsigned n = 0; n < NUM_NEURONS; n++)
                sum_r[n] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        relu_q   <= relu_en;
                        beat_idx <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (beat_idx == IDX_BITS'(NUM_INPUTS - 1)) begin
                            beat_idx <= '0;
                            in_ready <= 1'b0;
                            state    <= FINISH;
                        end else begin
                            beat_idx <= beat_idx + IDX_BITS'(1);
                        end
                    end
                end
                FINISH: begin
                    for (int unsigned n = 0; n < NUM_NEURONS; n++)
                        sum_r[n] <= biased[n];
                    fin_q <= 1'b1;
                    state <= OUTPUT;
                end
                OUTPUT: begin
                    if (fin_q) begin
                        fin_q     <= 1'b0;
                        out_valid <= 1'b1;
                        for (int unsigned n = 0; n < NUM_NEURONS; n++)
                            out_data[n*OUT_BITS +: OUT_BITS] <=
                                OUT_BITS'(sat_shift(64'(sum_r[n]), FRAC_SHIFT, OUT_BITS));
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Scoreboard bench: two instances (shift 0 and shift 2) share stimulus; monitors pop expectations.
module tb_dense_layer_seq;

    localparam int unsigned NI = 4;
    localparam int unsigned NN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic [47:0] bias = '0;
    logic        in_valid = 1'b0;
    logic signed [7:0] in_x = '0;
    logic [23:0] in_w = '0;
    logic        out_ready = 1'b1;

    logic        in_ready0, busy0, out_valid0;
    logic [23:0] out_data0;
    logic [1:0]  beat_idx0;
    logic        in_ready2, busy2, out_valid2;
    logic [23:0] out_data2;
    logic [1:0]  beat_idx2;

    int checks = 0;
    int fails  = 0;
    logic [23:0] q0[$];
    logic [23:0] q2[$];

    always #5 clk = ~clk;

    dense_layer_seq #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .IN_BITS(8), .W_BITS(8),
        .B_BITS(16), .OUT_BITS(8), .FRAC_SHIFT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready0), .in_x(in_x), .in_w(in_w),
        .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .beat_idx(beat_idx0)
    );

    dense_layer_seq #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .IN_BITS(8), .W_BITS(8),
        .B_BITS(16), .OUT_BITS(8), .FRAC_SHIFT(2)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready2), .in_x(in_x), .in_w(in_w),
        .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .beat_idx(beat_idx2)
    );

    function automatic logic [23:0] p3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [47:0] pb(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [31:0] px(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            checks++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL dut0_unexpected_output: got 0x%0h, expected no output", out_data0);
            end else begin
                logic [23:0] e;
                e = q0.pop_front();
                if (out_data0 !== e) begin
                    fails++;
                    $display("FAIL dut0_result: got 0x%0h, expected 0x%0h at %0t", out_data0, e, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready) begin
            checks++;
            if (q2.size() == 0) begin
                fails++;
                $display("FAIL dut2_unexpected_output: got 0x%0h, expected no output", out_data2);
            end else begin
                logic [23:0] e;
                e = q2.pop_front();
                if (out_data2 !== e) begin
                    fails++;
                    $display("FAIL dut2_result: got 0x%0h, expected 0x%0h at %0t", out_data2, e, $time);
                end
            end
        end
    end

    task automatic send_beat(input int i, input logic [31:0] xv, input logic [95:0] wv,
                             input bit gaps, input bit extra_start);
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                in_x = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        check("beat_idx", 32'(beat_idx0), 32'(i));
        check("in_ready", 32'(in_ready0), 32'd1);
        in_valid = 1'b1;
        in_x     = xv[i*8 +: 8];
        in_w     = wv[i*24 +: 24];
        start    = extra_start && (i == 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run(input logic [31:0] xv, input logic [95:0] wv, input logic [47:0] bv,
                       input logic relu, input logic [23:0] e0, input logic [23:0] e2,
                       input bit gaps, input int stall, input bit extra_start);
        int  lat;
        bit  seen;
        q0.push_back(e0);
        q2.push_back(e2);
        out_ready = (stall == 0);
        @(posedge clk); #1;
        start = 1'b1; relu_en = relu; bias = bv;
        @(posedge clk); #1;
        start = 1'b0; relu_en = ~relu;
        check("busy_after_start", 32'(busy0), 32'd1);
        for (int i = 0; i < NI; i++)
            send_beat(i, xv, wv, gaps, extra_start);
        lat = 0; seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid0) begin seen = 1; break; end
            @(posedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd2);
        check("out_valid_seen", 32'(seen), 32'd1);
        for (int k = 0; k < stall; k++) begin
            check("stall_data", 32'(out_data0), 32'(e0));
            check("stall_valid", 32'(out_valid0), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!out_valid0) break;
        end
        check("valid_drop", 32'(out_valid0), 32'd0);
        check("busy_drop", 32'(busy0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [95:0] w_t1;
        logic [95:0] w_sat;
        logic [95:0] w_t4;
        w_t1  = {4{p3(1, 2, 3)}};
        w_sat = {4{p3(127, 127, 127)}};
        w_t4  = {p3(0, 0, 0), p3(0, 0, 0), p3(0, 0, 0), p3(1, -1, 2)};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_in_ready", 32'(in_ready0), 32'd0);
        check("reset_out_valid", 32'(out_valid0), 32'd0);
        check("reset_out_data", 32'(out_data0), 32'd0);
        check("reset_beat_idx", 32'(beat_idx0), 32'd0);
        check("reset_out_data2", 32'(out_data2), 32'd0);

        // basic sums, bias/ReLU, linear
        run(px(1, 2, 3, 4), w_t1, pb(0, 0, 0), 1'b0, p3(10, 20, 30), p3(2, 5, 7), 0, 0, 0);
        run(px(1, 2, 3, 4), w_t1, pb(-15, -15, -15), 1'b1, p3(0, 5, 15), p3(0, 1, 3), 0, 0, 0);
        run(px(1, 2, 3, 4), w_t1, pb(-15, -15, -15), 1'b0, p3(-5, 5, 15), p3(-2, 1, 3), 0, 0, 0);
        // saturation both directions
        run(px(127, 127, 127, 127), w_sat, pb(0, 0, 0), 1'b0,
            p3(127, 127, 127), p3(127, 127, 127), 0, 0, 0);
        run(px(-128, -128, -128, -128), w_sat, pb(0, 0, 0), 1'b0,
            p3(-128, -128, -128), p3(-128, -128, -128), 0, 0, 0);
        // floor shift: -7 -> -2, 7 -> 1, -14 -> -4
        run(px(-7, 0, 0, 0), w_t4, pb(0, 0, 0), 1'b0, p3(-7, 7, -14), p3(-2, 1, -4), 0, 0, 0);
        // input gaps and output backpressure
        run(px(1, 2, 3, 4), w_t1, pb(0, 0, 0), 1'b0, p3(10, 20, 30), p3(2, 5, 7), 1, 5, 0);

        // abort after two beats
        @(posedge clk); #1;
        start = 1'b1; relu_en = 1'b0; bias = '0;
        @(posedge clk); #1;
        start = 1'b0;
        send_beat(0, px(1, 2, 3, 4), w_t1, 0, 0);
        send_beat(1, px(1, 2, 3, 4), w_t1, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_in_ready", 32'(in_ready0), 32'd0);
        check("abort_out_valid", 32'(out_valid0), 32'd0);
        check("abort_beat_idx", 32'(beat_idx0), 32'd0);
        check("abort_out_data", 32'(out_data0), 32'd0);
        check("abort_out_data2", 32'(out_data2), 32'd0);

        // clean run after abort, with a start pulse mid-accumulation
        run(px(1, 2, 3, 4), w_t1, pb(0, 0, 0), 1'b0, p3(10, 20, 30), p3(2, 5, 7), 0, 0, 1);

        repeat (3) @(posedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
